// File: rtl/exp8243_pkg.sv
// rtl/exp8243_pkg.sv - shared types and helpers for the 8243 expander responder
`timescale 1ns/1ps
package exp8243_pkg;

   localparam int NPORT = 4;

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_OR    = 2'b10,
      OP_AND   = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      IDLE,
      RD_TURN,
      RD_DRIVE,
      RELEASE,
      WR_WAIT
   } state_e;

   function automatic logic [3:0] apply_op(input op_e op, input logic [3:0] cur,
                                           input logic [3:0] data);
      case (op)
         OP_OR:   return cur | data;
         OP_AND:  return cur & data;
         default: return data;
      endcase
   endfunction

endpackage

// File: rtl/exp8243_sync.sv
// rtl/exp8243_sync.sv - PROG/P2 synchronizers, P2 history and edge pulses
`timescale 1ns/1ps
module exp8243_sync (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       prog_n,
   input  logic [3:0] p2_i,
   output logic       prog_fall,
   output logic       prog_rise,
   output logic [3:0] cmd,
   output logic [3:0] data
);

   logic       prog_s1, prog_s2, prog_d;
   logic [3:0] p2_s1, p2_s2, h1, h2;

   // Synchronizers reset low so a fall is only seen after PROG has first been sampled high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prog_s1 <= 1'b0;
         prog_s2 <= 1'b0;
         prog_d  <= 1'b0;
         p2_s1   <= 4'h0;
         p2_s2   <= 4'h0;
         h1      <= 4'h0;
         h2      <= 4'h0;
      end else begin
         prog_s1 <= prog_n;
         prog_s2 <= prog_s1;
         prog_d  <= prog_s2;
         p2_s1   <= p2_i;
         p2_s2   <= p2_s1;
         h1      <= p2_s2;
         h2      <= h1;
      end
   end

   assign prog_fall = prog_d & ~prog_s2;
   assign prog_rise = ~prog_d & prog_s2;
   assign cmd       = h1;
   assign data      = h2;

endmodule

// File: rtl/exp8243_responder.sv
// rtl/exp8243_responder.sv - 8243-style expander bus responder with four 4-bit ports
`timescale 1ns/1ps
module exp8243_responder import exp8243_pkg::*; #(
   parameter int         TURN_CYC     = 4,
   parameter logic [3:0] RST_PORT_VAL = 4'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        prog_n,
   input  logic [3:0]  p2_i,
   output logic [3:0]  p2_o,
   output logic        p2_oe,
   output logic        p2_buf_oe,
   output logic        p2_buf_dir,
   input  logic [15:0] port_in,
   output logic [15:0] port_out,
   output logic [3:0]  port_oe,
   output logic [3:0]  wr_stb,
   output logic [3:0]  rd_stb
);

   localparam int CW = (TURN_CYC < 2) ? 1 : $clog2(TURN_CYC);

   logic          prog_fall, prog_rise;
   logic [3:0]    sync_cmd, sync_data;
   state_e        state_q, state_d;
   op_e           op_q;
   logic [1:0]    addr_q;
   logic [CW-1:0] turn_cnt;
   logic          latch_cmd, enter_drive, rd_done, wr_done;

   exp8243_sync u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .prog_n    (prog_n),
      .p2_i      (p2_i),
      .prog_fall (prog_fall),
      .prog_rise (prog_rise),
      .cmd       (sync_cmd),
      .data      (sync_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      latch_cmd   = 1'b0;
      enter_drive = 1'b0;
      rd_done     = 1'b0;
      wr_done     = 1'b0;
      p2_oe       = 1'b0;
      p2_buf_oe   = 1'b0;
      p2_buf_dir  = 1'b0;
      p2_o        = 4'h0;
      case (state_q)
         IDLE: begin
            if (prog_fall) begin
               latch_cmd = 1'b1;
               state_d   = (op_e'(sync_cmd[3:2]) == OP_READ) ? RD_TURN : WR_WAIT;
            end
         end
         RD_TURN: begin
            // Translator disabled while the host may still be holding the command.
            p2_buf_oe = 1'b1;
            if (prog_rise) begin
               state_d = RELEASE;
            end else if (turn_cnt == CW'(TURN_CYC - 1)) begin
               enter_drive = 1'b1;
               state_d     = RD_DRIVE;
            end
         end
         RD_DRIVE: begin
            p2_oe      = 1'b1;
            p2_buf_dir = 1'b1;
            p2_o       = port_in[{addr_q, 2'b00} +: 4];
            if (prog_rise) begin
               rd_done = 1'b1;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            p2_buf_oe = 1'b1;
            state_d   = IDLE;
         end
         WR_WAIT: begin
            if (prog_rise) begin
               wr_done = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                turn_cnt <= '0;
      else if (state_q != RD_TURN) turn_cnt <= '0;
      else                       turn_cnt <= turn_cnt + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= OP_READ;
         addr_q   <= 2'd0;
         port_out <= {NPORT{RST_PORT_VAL}};
         port_oe  <= 4'h0;
         wr_stb   <= 4'h0;
         rd_stb   <= 4'h0;
      end else begin
         wr_stb <= 4'h0;
         rd_stb <= 4'h0;
         if (latch_cmd) begin
            op_q   <= op_e'(sync_cmd[3:2]);
            addr_q <= sync_cmd[1:0];
         end
         if (enter_drive) port_oe[addr_q] <= 1'b0;
         if (rd_done)     rd_stb[addr_q]  <= 1'b1;
         if (wr_done) begin
            port_out[{addr_q, 2'b00} +: 4] <=
               apply_op(op_q, port_out[{addr_q, 2'b00} +: 4], sync_data);
            port_oe[addr_q] <= 1'b1;
            wr_stb[addr_q]  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_exp8243_responder.sv
// tb/tb_exp8243_responder.sv - scoreboard bench for exp8243_responder
`timescale 1ns/1ps
module tb_exp8243_responder;
   import exp8243_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        prog_n;
   logic [3:0]  p2_i;
   logic [3:0]  p2_o;
   logic        p2_oe, p2_buf_oe, p2_buf_dir;
   logic [15:0] port_in;
   logic [15:0] port_out;
   logic [3:0]  port_oe, wr_stb, rd_stb;

   logic        host_drv;
   logic [3:0]  host_val;

   typedef struct packed {
      logic [3:0]  wr;
      logic [3:0]  rd;
      logic [15:0] pout;
      logic [3:0]  poe;
   } ev_t;

   ev_t         sb_q[$];
   logic [15:0] exp_out;
   logic [3:0]  exp_oe;
   int          n_checks = 0;
   int          n_fail = 0;
   int          drive_cnt = 0;
   int          overlap_cnt = 0;
   logic        chk_idle = 1'b0;

   always #10 clk = ~clk;

   assign p2_i = p2_oe ? p2_o : (host_drv ? host_val : 4'h0);

   exp8243_responder dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .prog_n     (prog_n),
      .p2_i       (p2_i),
      .p2_o       (p2_o),
      .p2_oe      (p2_oe),
      .p2_buf_oe  (p2_buf_oe),
      .p2_buf_dir (p2_buf_dir),
      .port_in    (port_in),
      .port_out   (port_out),
      .port_oe    (port_oe),
      .wr_stb     (wr_stb),
      .rd_stb     (rd_stb)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the expected event whenever a strobe appears.
   always @(negedge clk) begin
      ev_t e;
      if (chk_idle) begin
         check("stb_one_cycle", {24'h0, wr_stb, rd_stb}, 32'h0);
         chk_idle = 1'b0;
      end else if (wr_stb != 4'h0 || rd_stb != 4'h0) begin
         if (sb_q.size() == 0) begin
            check("unexpected_stb", {24'h0, wr_stb, rd_stb}, 32'h0);
         end else begin
            e = sb_q.pop_front();
            check("wr_stb", {28'h0, wr_stb}, {28'h0, e.wr});
            check("rd_stb", {28'h0, rd_stb}, {28'h0, e.rd});
            check("port_out", {16'h0, port_out}, {16'h0, e.pout});
            check("port_oe", {28'h0, port_oe}, {28'h0, e.poe});
         end
         chk_idle = 1'b1;
      end
      if (p2_oe) begin
         drive_cnt++;
         if (host_drv) overlap_cnt++;
      end
   end

   task automatic host_write(input op_e op, input logic [1:0] addr, input logic [3:0] data,
                             input logic [3:0] exp_nib, input bit push);
      if (push) begin
         exp_out[{addr, 2'b00} +: 4] = exp_nib;
         exp_oe[addr] = 1'b1;
         sb_q.push_back('{wr: 4'(1) << addr, rd: 4'h0, pout: exp_out, poe: exp_oe});
      end
      @(posedge clk); #3;
      host_val = {op, addr};
      host_drv = 1'b1;
      #50 prog_n = 1'b0;
      #60 host_val = ~data;
      #440 host_val = data;
      #200 prog_n = 1'b1;
      #20 host_drv = 1'b0;
      host_val = 4'h0;
      repeat (10) @(posedge clk);
   endtask

   task automatic host_read(input logic [1:0] addr, input logic [3:0] exp_nib);
      int cyc;
      exp_oe[addr] = 1'b0;
      sb_q.push_back('{wr: 4'h0, rd: 4'(1) << addr, pout: exp_out, poe: exp_oe});
      @(posedge clk); #3;
      host_val = {OP_READ, addr};
      host_drv = 1'b1;
      #50 prog_n = 1'b0;
      #60 host_drv = 1'b0;
      #637;
      check("rd_p2_oe", {31'h0, p2_oe}, 32'h1);
      check("rd_buf_oe", {31'h0, p2_buf_oe}, 32'h0);
      check("rd_buf_dir", {31'h0, p2_buf_dir}, 32'h1);
      check("rd_host_sample", {28'h0, p2_i}, {28'h0, exp_nib});
      #3 prog_n = 1'b1;
      cyc = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         cyc = i;
         if (!p2_oe) break;
      end
      check("release_within_3", {31'h0, (cyc <= 3)}, 32'h1);
      repeat (10) @(posedge clk);
   endtask

   task automatic abort_read(input logic [1:0] addr);
      int snap;
      snap = drive_cnt;
      @(posedge clk); #3;
      host_val = {OP_READ, addr};
      host_drv = 1'b1;
      #50 prog_n = 1'b0;
      for (int i = 0; i < 20 && !p2_buf_oe; i++) begin
         @(posedge clk); #1;
      end
      check("abort_turn_seen", {31'h0, p2_buf_oe}, 32'h1);
      prog_n = 1'b1;
      #20 host_drv = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check("abort_no_drive", drive_cnt - snap, 32'h0);
      check("abort_idle_buf_oe", {31'h0, p2_buf_oe}, 32'h0);
      check("abort_idle_dir", {31'h0, p2_buf_dir}, 32'h0);
      check("abort_port_oe", {28'h0, port_oe}, {28'h0, exp_oe});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      prog_n   = 1'b1;
      host_drv = 1'b0;
      host_val = 4'h0;
      port_in  = 16'h0000;
      exp_out  = 16'h0000;
      exp_oe   = 4'h0;
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("reset_p2_oe", {31'h0, p2_oe}, 32'h0);
      check("reset_buf_oe", {31'h0, p2_buf_oe}, 32'h0);
      check("reset_buf_dir", {31'h0, p2_buf_dir}, 32'h0);
      check("reset_port_oe", {28'h0, port_oe}, 32'h0);
      check("reset_port_out", {16'h0, port_out}, 32'h0);

      host_write(OP_WRITE, 2'd1, 4'hA, 4'hA, 1'b1);
      host_write(OP_WRITE, 2'd3, 4'hF, 4'hF, 1'b1);
      host_write(OP_AND,   2'd3, 4'hD, 4'hD, 1'b1);
      host_write(OP_OR,    2'd3, 4'h2, 4'hF, 1'b1);

      port_in = 16'h0690;
      host_read(2'd2, 4'h6);
      host_read(2'd1, 4'h9);
      abort_read(2'd3);

      fork
         host_write(OP_WRITE, 2'd0, 4'h5, 4'h5, 1'b0);
         begin
            #300 rst_n = 1'b0;
            #60  rst_n = 1'b1;
         end
      join
      #1;
      check("post_reset_port_out", {16'h0, port_out}, 32'h0);
      check("post_reset_port_oe", {28'h0, port_oe}, 32'h0);
      exp_out = 16'h0000;
      exp_oe  = 4'h0;

      host_write(OP_WRITE, 2'd0, 4'h5, 4'h5, 1'b1);
      repeat (10) @(posedge clk);
      check("scoreboard_drained", sb_q.size(), 32'h0);
      check("no_bus_overlap", overlap_cnt, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/exp8243_responder.md
Name: exp8243_responder

Overview:
- Synthesizable FPGA-side responder for the OKI/Intel 8243-style 4-bit expander bus (PROG strobe + 4-bit P2 bus) driven by the host MCU.
- Decodes READ/WRITE/OR/AND commands to four 4-bit expander ports (addr 0..3 = P4..P7).
- Drives the P2 bus and the external level translator during reads.
- Exposes port registers and strobes to fabric logic (e.g. UART bridge).

Parameters:
- TURN_CYC, 4, clk cycles between read detection and buffer enable; must cover the 60 ns host hold; default sized for 48 MHz.
- RST_PORT_VAL, 4'h0, reset value of every port output register.

Ports:
- clk  in  1  system clock; period must be ≤50 ns (48 MHz nominal, from PLL).
- rst_n  in  1  asynchronous, active-low reset.
- prog_n  in  1  host PROG strobe, asynchronous.
- p2_i  in  4  P2 bus as seen by the FPGA, asynchronous.
- p2_o  out  4  P2 drive value.
- p2_oe  out  1  FPGA-side P2 tristate enable.
- p2_buf_oe  out  1  level-translator enable, active-low.
- p2_buf_dir  out  1  translator direction: 1 = FPGA→MCU, 0 = MCU→FPGA.
- port_in  in  16  fabric inputs, nibble k = port k.
- port_out  out  16  port output registers, nibble k = port k.
- port_oe  out  4  per-port output mode (1 = output, 0 = input).
- wr_stb  out  4  one-cycle pulse per port after any WRITE/OR/AND completes.
- rd_stb  out  4  one-cycle pulse per port when a READ completes.

Behaviour:
- Reset values (async assert): port_out = {4{RST_PORT_VAL}}, port_oe = 0, p2_oe = 0, p2_o = 0, p2_buf_oe = 0 (enabled), p2_buf_dir = 0, strobes = 0, FSM = IDLE.
- Reset deassert mid-transaction: FSM stays IDLE until prog_n is synchronized high, so a partial cycle is never decoded.
- Sync: prog_n uses a 2-FF synchronizer. p2_i passes through a matching 2-FF stage, then a 2-deep history (h1 = one cycle older, h2 = two older).
- Command capture: on the first synchronized-low sample of prog_n, cmd ← h1. With period ≤50 ns this lies in [fall−50, fall+60] ns. cmd[3:2] = op, cmd[1:0] = addr.
- Data capture: on the first synchronized-high sample of prog_n, data ← h2. This lies in the 200 ns setup window.
- FSM states:
  - IDLE: wait for prog fall; latch cmd.
    - op = READ → RD_TURN; assert p2_buf_oe = 1 (disable translator).
    - Other ops → WR_WAIT.
  - RD_TURN: count TURN_CYC cycles.
    - Then p2_buf_dir = 1, p2_oe = 1, p2_o = port_in[addr], port_oe[addr] = 0; go to RD_DRIVE.
    - prog rise seen first → RELEASE (abort, no rd_stb).
  - RD_DRIVE: p2_o tracks port_in[addr] each cycle; p2_buf_oe = 0. On prog rise: pulse rd_stb[addr], go to RELEASE.
  - RELEASE: one cycle with p2_oe = 0, p2_buf_oe = 1, p2_buf_dir = 0. Next cycle p2_buf_oe = 0; go to IDLE.
    - P2 is released within 3 clk of the prog rise.
  - WR_WAIT: on prog rise, apply to port_out[addr]:
    - WRITE: ← data
    - OR: ← port_out | data
    - AND: ← port_out & data
    - Then set port_oe[addr] = 1, pulse wr_stb[addr] the same cycle, go to IDLE.
- Read-to-P2 valid latency: ≤ 2 + 1 + TURN_CYC + 1 cycles after the fall (≈166 ns at 48 MHz), well under the 700 ns t_prog.
- READ of any port forces that port to input mode. WRITE/OR/AND force it to output mode.
- Other ports are untouched by any transaction.
- Glitch rule: a prog_n low pulse shorter than 2 synchronized cycles may be missed. Such a pulse must never produce a partial write.

Decomposition:
- Package exp8243_pkg:
  - op enum {OP_READ=2'b00, OP_WRITE=2'b01, OP_OR=2'b10, OP_AND=2'b11}.
  - FSM state enum {IDLE, RD_TURN, RD_DRIVE, RELEASE, WR_WAIT}.
  - Port-count constant NPORT=4.
- Sub-module exp8243_sync: prog_n/p2_i synchronizers, p2 history, fall/rise pulses, cmd/data sample outputs.

Test Plan:
- Reset released, no traffic → p2_oe = 0, p2_buf_oe = 0, p2_buf_dir = 0, port_oe = 0, port_out = 0x0000.
- WRITE addr1 data 4'hA (50/60/700/200/20 ns host timing) → port_out[7:4] = A, port_oe = 4'b0010, wr_stb = 4'b0010 for 1 cycle.
- port_out[15:12] = 4'b1111, then AND addr3 data 4'b1101 → port_out[15:12] = 4'b1101. Then OR addr3 data 4'b0010 → 4'b1111.
- port_in[11:8] = 4'h6, READ addr2 → host samples 4'h6 at t_prog; port_oe[2] = 0; rd_stb[2] pulse. Release within 3 clk of rise, with no overlap between host drive and p2_oe.
- READ with prog_n raised 2 cycles after detection (inside TURN_CYC) → no P2 drive, no rd_stb, FSM back in IDLE.
- rst_n asserted during WR_WAIT of WRITE addr0 data 4'h5 → port_out[3:0] = 0 after reset, no wr_stb. The next full WRITE decodes correctly.
